// File: rtl/picomips_ctrl_if.sv
// ROM fetch and ALU control bundle between the picoMips sequencer and its datapath.
interface picomips_ctrl_if #(parameter int PCW = 5);
  logic [11:0]    Instr;
  logic [PCW-1:0] PC;
  logic [7:0]     Acc;
  logic           WE;
  logic           UseMul;
  logic           UseA;
  logic [7:0]     DataA;
  logic [7:0]     DataB;

  modport master (input Instr, Acc, output PC, WE, UseMul, UseA, DataA, DataB);
  modport slave  (output Instr, Acc, input PC, WE, UseMul, UseA, DataA, DataB);
endinterface

// File: rtl/picomips_ctrl.sv
// picoMips program sequencer: fetches from a combinational ROM, decodes into ALU
// controls, and handles button-handshaked switch input, output latch, branches and halt.
module picomips_ctrl #(
  parameter int PCW         = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                Clock,
  input  logic                nReset,
  picomips_ctrl_if.master     bus,
  input  logic [7:0]          Sw,
  input  logic                Btn,
  output logic [7:0]          OutData,
  output logic                OutValid,
  output logic                Halted,
  output logic                Illegal
);

  typedef enum logic [1:0] {S_RUN, S_STALL, S_HALT} state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_MULI = 4'h3;
  localparam logic [3:0] OP_LDSW = 4'h4;
  localparam logic [3:0] OP_WAIT = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_BZ   = 4'h7;
  localparam logic [3:0] OP_OUT  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t                          state_q, state_d;
  logic [PCW-1:0]                  pc_q, pc_d, pc_inc;
  logic [7:0]                      sw_reg_q, sw_reg_d;
  logic [7:0]                      out_data_q, out_data_d;
  logic                            out_valid_q, out_valid_d;
  logic                            illegal_q, illegal_d;
  logic [SYNC_STAGES-1:0]          btn_sync_q, btn_sync_d;
  logic [SYNC_STAGES-1:0][7:0]     sw_sync_q, sw_sync_d;
  logic                            btn_prev_q, btn_prev_d;
  logic                            btn_edge;
  logic [3:0]                      op;
  logic [7:0]                      imm;
  logic                            we, use_mul, use_a;

  assign op     = bus.Instr[11:8];
  assign imm    = bus.Instr[7:0];
  assign pc_inc = pc_q + 1'b1;

  // Edge detect runs every cycle, so a press while not waiting is simply consumed.
  always_comb begin
    btn_sync_d = {btn_sync_q[SYNC_STAGES-2:0], Btn};
    sw_sync_d  = {sw_sync_q[SYNC_STAGES-2:0], Sw};
    btn_prev_d = btn_sync_q[SYNC_STAGES-1];
  end
  assign btn_edge = btn_sync_q[SYNC_STAGES-1] & ~btn_prev_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    sw_reg_d    = sw_reg_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    illegal_d   = illegal_q;
    we          = 1'b0;
    use_mul     = 1'b0;
    use_a       = 1'b0;
    case (state_q)
      S_RUN: begin
        case (op)
          OP_NOP:  pc_d = pc_inc;
          OP_LDI:  begin we = 1'b1; pc_d = pc_inc; end
          OP_ADDI: begin we = 1'b1; use_a = 1'b1; pc_d = pc_inc; end
          OP_MULI: begin we = 1'b1; use_a = 1'b1; use_mul = 1'b1; pc_d = pc_inc; end
          OP_LDSW: begin we = 1'b1; pc_d = pc_inc; end
          OP_WAIT: begin
            if (btn_edge) begin
              sw_reg_d = sw_sync_q[SYNC_STAGES-1];
              pc_d     = pc_inc;
            end else begin
              state_d = S_STALL;
            end
          end
          OP_JMP:  pc_d = imm[PCW-1:0];
          OP_BZ:   pc_d = (bus.Acc == 8'd0) ? imm[PCW-1:0] : pc_inc;
          OP_OUT:  begin out_data_d = bus.Acc; out_valid_d = 1'b1; pc_d = pc_inc; end
          OP_HALT: state_d = S_HALT;
          default: begin illegal_d = 1'b1; pc_d = pc_inc; end
        endcase
      end
      S_STALL: begin
        if (btn_edge) begin
          sw_reg_d = sw_sync_q[SYNC_STAGES-1];
          pc_d     = pc_inc;
          state_d  = S_RUN;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= S_RUN;
      pc_q        <= '0;
      sw_reg_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      btn_sync_q  <= '0;
      sw_sync_q   <= '0;
      btn_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      sw_reg_q    <= sw_reg_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
      btn_sync_q  <= btn_sync_d;
      sw_sync_q   <= sw_sync_d;
      btn_prev_q  <= btn_prev_d;
    end
  end

  assign bus.PC     = pc_q;
  assign bus.WE     = we;
  assign bus.UseMul = use_mul;
  assign bus.UseA   = use_a;
  assign bus.DataA  = sw_reg_q;
  assign bus.DataB  = (op == OP_LDSW) ? 8'd0 : imm;
  assign OutData    = out_data_q;
  assign OutValid   = out_valid_q;
  assign Halted     = (state_q == S_HALT);
  assign Illegal    = illegal_q;

endmodule

// File: tb/tb_picomips_ctrl.sv
// Bench for picomips_ctrl: ROM + accumulator model around the sequencer, decode table and corner sequences.
module tb_picomips_ctrl;
  localparam int PCW = 5;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic [7:0]  Sw = 8'd0;
  logic        Btn = 1'b0;
  logic [7:0]  OutData;
  logic        OutValid, Halted, Illegal;
  logic [11:0] rom [32];
  logic [7:0]  acc, op1, alu_res;
  logic [15:0] prod;

  int n_chk = 0;
  int n_fail = 0;
  int out_pulses = 0;
  logic [7:0] out_q [$];

  picomips_ctrl_if #(.PCW(PCW)) bus ();

  picomips_ctrl #(.PCW(PCW), .SYNC_STAGES(2)) dut (
    .Clock(Clock), .nReset(nReset), .bus(bus), .Sw(Sw), .Btn(Btn),
    .OutData(OutData), .OutValid(OutValid), .Halted(Halted), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  // Environment: combinational ROM and accumulator datapath.
  assign bus.Instr = rom[bus.PC];
  assign bus.Acc   = acc;

  always_comb begin
    op1     = bus.UseA ? acc : bus.DataA;
    prod    = op1 * bus.DataB;
    alu_res = bus.UseMul ? prod[7:0] : op1 + bus.DataB;
  end

  always @(posedge Clock or negedge nReset) begin
    if (!nReset) acc <= 8'd0;
    else if (bus.WE) acc <= alu_res;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output scoreboard: every OutValid pulse must match a queued expectation.
  always @(negedge Clock) begin
    if (nReset && OutValid) begin
      out_pulses++;
      if (out_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL out_unexpected: got %0h expected none", OutData);
      end else begin
        chk("out_data", {24'd0, OutData}, {24'd0, out_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic load_nops();
    for (int i = 0; i < 32; i++) rom[i] = 12'h000;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    nReset = 1'b0;
    repeat (2) @(negedge Clock);
    nReset = 1'b1;
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] imm;
    logic       we, mul, usea;
    logic [7:0] datab;
    logic [4:0] pc1;
    logic       halt, ill;
  } vec_t;

  vec_t vecs [12];
  vec_t exp_q [$];

  initial begin : main
    vec_t e;
    int we_cnt, mul_cnt, cyc;

    vecs[0]  = '{4'h0, 8'h12, 1'b0, 1'b0, 1'b0, 8'h12, 5'd1,  1'b0, 1'b0};
    vecs[1]  = '{4'h1, 8'h05, 1'b1, 1'b0, 1'b0, 8'h05, 5'd1,  1'b0, 1'b0};
    vecs[2]  = '{4'h2, 8'h07, 1'b1, 1'b0, 1'b1, 8'h07, 5'd1,  1'b0, 1'b0};
    vecs[3]  = '{4'h3, 8'h03, 1'b1, 1'b1, 1'b1, 8'h03, 5'd1,  1'b0, 1'b0};
    vecs[4]  = '{4'h4, 8'h33, 1'b1, 1'b0, 1'b0, 8'h00, 5'd1,  1'b0, 1'b0};
    vecs[5]  = '{4'h5, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0,  1'b0, 1'b0};
    vecs[6]  = '{4'h6, 8'h2B, 1'b0, 1'b0, 1'b0, 8'h2B, 5'd11, 1'b0, 1'b0};
    vecs[7]  = '{4'h7, 8'h07, 1'b0, 1'b0, 1'b0, 8'h07, 5'd7,  1'b0, 1'b0};
    vecs[8]  = '{4'h8, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1,  1'b0, 1'b0};
    vecs[9]  = '{4'hF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0,  1'b1, 1'b0};
    vecs[10] = '{4'hC, 8'h44, 1'b0, 1'b0, 1'b0, 8'h44, 5'd1,  1'b0, 1'b1};
    vecs[11] = '{4'h9, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1,  1'b0, 1'b1};

    // Reset state, then first fetch of a NOP.
    load_nops();
    repeat (2) @(negedge Clock);
    chk("rst_pc", {27'd0, bus.PC}, 32'd0);
    chk("rst_outvalid", {31'd0, OutValid}, 32'd0);
    chk("rst_halted", {31'd0, Halted}, 32'd0);
    chk("rst_illegal", {31'd0, Illegal}, 32'd0);
    chk("rst_outdata", {24'd0, OutData}, 32'd0);
    nReset = 1'b1;
    tick();
    chk("first_pc", {27'd0, bus.PC}, 32'd1);

    // Single-instruction decode table.
    foreach (vecs[i]) begin
      load_nops();
      rom[0] = {vecs[i].op, vecs[i].imm};
      if (vecs[i].op == 4'h8) out_q.push_back(8'd0);
      exp_q.push_back(vecs[i]);
      do_reset();
      e = exp_q.pop_front();
      chk($sformatf("v%0d_we", i),    {31'd0, bus.WE},     {31'd0, e.we});
      chk($sformatf("v%0d_mul", i),   {31'd0, bus.UseMul}, {31'd0, e.mul});
      chk($sformatf("v%0d_usea", i),  {31'd0, bus.UseA},   {31'd0, e.usea});
      chk($sformatf("v%0d_datab", i), {24'd0, bus.DataB},  {24'd0, e.datab});
      tick();
      chk($sformatf("v%0d_pc", i),    {27'd0, bus.PC},     {27'd0, e.pc1});
      chk($sformatf("v%0d_halt", i),  {31'd0, Halted},     {31'd0, e.halt});
      chk($sformatf("v%0d_ill", i),   {31'd0, Illegal},    {31'd0, e.ill});
    end
    tick();

    // LDI 5; MULI 3; OUT; HALT
    load_nops();
    rom[0] = 12'h105; rom[1] = 12'h303; rom[2] = 12'h800; rom[3] = 12'hF00;
    out_q.push_back(8'd15);
    out_pulses = 0;
    do_reset();
    we_cnt = 0; mul_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.WE) we_cnt++;
      if (bus.UseMul) mul_cnt++;
      tick();
    end
    chk("prog_we_cycles", we_cnt, 32'd2);
    chk("prog_mul_cycles", mul_cnt, 32'd1);
    chk("prog_outdata", {24'd0, OutData}, 32'd15);
    chk("prog_out_pulses", out_pulses, 32'd1);
    chk("prog_halted", {31'd0, Halted}, 32'd1);
    chk("prog_pc", {27'd0, bus.PC}, 32'd3);
    chk("prog_outq_empty", out_q.size(), 32'd0);

    // WAIT at PC=2 with a button press after ten stalled cycles.
    load_nops();
    rom[2] = 12'h500;
    Sw = 8'hA5;
    do_reset();
    tick(); tick();
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("wait_hold_pc", {27'd0, bus.PC}, 32'd2);
      chk("wait_hold_we", {31'd0, bus.WE}, 32'd0);
    end
    Btn = 1'b1;
    tick();
    chk("wait_sync1_pc", {27'd0, bus.PC}, 32'd2);
    tick();
    chk("wait_sync2_pc", {27'd0, bus.PC}, 32'd2);
    tick();
    chk("wait_adv_pc", {27'd0, bus.PC}, 32'd3);
    chk("wait_swreg", {24'd0, bus.DataA}, 32'hA5);
    Btn = 1'b0;

    // Button held across two WAITs needs release and a new press.
    load_nops();
    rom[0] = 12'h500; rom[1] = 12'h500;
    do_reset();
    Btn = 1'b1;
    cyc = 0;
    while (bus.PC != 5'd1 && cyc < 8) begin tick(); cyc++; end
    chk("held_first_wait", {27'd0, bus.PC}, 32'd1);
    repeat (6) tick();
    chk("held_no_second", {27'd0, bus.PC}, 32'd1);
    Btn = 1'b0;
    repeat (3) tick();
    chk("held_release", {27'd0, bus.PC}, 32'd1);
    Btn = 1'b1;
    cyc = 0;
    while (bus.PC != 5'd2 && cyc < 8) begin tick(); cyc++; end
    chk("held_second_press", {27'd0, bus.PC}, 32'd2);
    Btn = 1'b0;

    // BZ sees the accumulator written by the preceding LDI.
    load_nops();
    rom[0] = 12'h101; rom[1] = 12'h707;
    do_reset();
    tick(); tick();
    chk("bz_nonzero_pc", {27'd0, bus.PC}, 32'd2);
    load_nops();
    rom[0] = 12'h100; rom[1] = 12'h709;
    do_reset();
    tick(); tick();
    chk("bz_zero_pc", {27'd0, bus.PC}, 32'd9);

    // Jump to the last address, then increment wraps to zero.
    load_nops();
    rom[0] = 12'h61F;
    do_reset();
    tick();
    chk("jmp_last_pc", {27'd0, bus.PC}, 32'd31);
    tick();
    chk("wrap_pc", {27'd0, bus.PC}, 32'd0);

    // Illegal opcode, then stall, then asynchronous reset mid-stall.
    load_nops();
    rom[0] = 12'hC44; rom[1] = 12'h500;
    do_reset();
    chk("ill_we", {31'd0, bus.WE}, 32'd0);
    tick();
    chk("ill_flag", {31'd0, Illegal}, 32'd1);
    chk("ill_pc", {27'd0, bus.PC}, 32'd1);
    tick(); tick();
    chk("stall_pc", {27'd0, bus.PC}, 32'd1);
    chk("stall_we", {31'd0, bus.WE}, 32'd0);
    chk("stall_ill_sticky", {31'd0, Illegal}, 32'd1);
    #2 nReset = 1'b0;
    #1;
    chk("arst_pc", {27'd0, bus.PC}, 32'd0);
    chk("arst_ill", {31'd0, Illegal}, 32'd0);
    chk("arst_halted", {31'd0, Halted}, 32'd0);
    @(negedge Clock);
    nReset = 1'b1;
    tick();
    chk("arst_run_pc", {27'd0, bus.PC}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
